axi4_id_slave_mem: RTL and testbench

AXI4 slave with burst and ID support, backed by an internal word-addressed memory. It sits directly downstream of the ID-capable AXI4 test master and consumes its AW/W/AR traffic. Writes are serviced in order, one burst at a time. Up to RD_SLOTS read bursts are held outstanding and their R beats are interleaved round-robin per beat, so the master's per-ID beat tracking is exercised.

---
 rtl/axi4_id_slave_mem.sv | 223 ++++++++++++++++++++++
 tb/tb_axi4_id_slave_mem.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_id_slave_mem.sv
`timescale 1ns/1ps
// AXI4 slave over a word-addressed memory: in-order burst writes, up to RD_SLOTS
// outstanding read bursts whose R beats are interleaved round-robin per beat.
module axi4_id_slave_mem #(
   parameter int ID_W      = 4,
   parameter int MEM_WORDS = 64,
   parameter int RD_SLOTS  = 4
) (
   input  logic            ACLK,
   input  logic            ARESETn,
   input  logic [ID_W-1:0] S_AXI_AWID,
   input  logic [31:0]     S_AXI_AWADDR,
   input  logic [7:0]      S_AXI_AWLEN,
   input  logic [2:0]      S_AXI_AWSIZE,
   input  logic [1:0]      S_AXI_AWBURST,
   input  logic [2:0]      S_AXI_AWPROT,
   input  logic [3:0]      S_AXI_AWCACHE,
   input  logic            S_AXI_AWLOCK,
   input  logic [3:0]      S_AXI_AWQOS,
   input  logic [3:0]      S_AXI_AWREGION,
   input  logic            S_AXI_AWVALID,
   output logic            S_AXI_AWREADY,
   input  logic [31:0]     S_AXI_WDATA,
   input  logic [3:0]      S_AXI_WSTRB,
   input  logic            S_AXI_WLAST,
   input  logic            S_AXI_WVALID,
   output logic            S_AXI_WREADY,
   output logic [ID_W-1:0] S_AXI_BID,
   output logic [1:0]      S_AXI_BRESP,
   output logic            S_AXI_BVALID,
   input  logic            S_AXI_BREADY,
   input  logic [ID_W-1:0] S_AXI_ARID,
   input  logic [31:0]     S_AXI_ARADDR,
   input  logic [7:0]      S_AXI_ARLEN,
   input  logic [2:0]      S_AXI_ARSIZE,
   input  logic [1:0]      S_AXI_ARBURST,
   input  logic [2:0]      S_AXI_ARPROT,
   input  logic [3:0]      S_AXI_ARCACHE,
   input  logic            S_AXI_ARLOCK,
   input  logic [3:0]      S_AXI_ARQOS,
   input  logic [3:0]      S_AXI_ARREGION,
   input  logic            S_AXI_ARVALID,
   output logic            S_AXI_ARREADY,
   output logic [ID_W-1:0] S_AXI_RID,
   output logic [31:0]     S_AXI_RDATA,
   output logic [1:0]      S_AXI_RRESP,
   output logic            S_AXI_RLAST,
   output logic            S_AXI_RVALID,
   input  logic            S_AXI_RREADY
);
   // state  | meaning
   // W_IDLE | waiting for an AW handshake
   // W_DATA | accepting W beats of the captured burst
   // W_RESP | presenting B until BREADY

   localparam int IDX_W  = $clog2(MEM_WORDS);
   localparam int SLOT_W = $clog2(RD_SLOTS);

   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

   w_state_t        w_state, w_next;
   logic            ready_en;
   logic [ID_W-1:0] w_id;
   logic [IDX_W-1:0] w_idx;
   logic [7:0]      w_len, w_cnt;
   logic            w_fixed, w_err;
   logic            aw_hs, w_hs, w_final;

   logic [31:0]     mem [MEM_WORDS];

   logic [RD_SLOTS-1:0] s_valid, s_fixed;
   logic [ID_W-1:0]     s_id  [RD_SLOTS];
   logic [IDX_W-1:0]    s_idx [RD_SLOTS];
   logic [7:0]          s_rem [RD_SLOTS];
   logic [SLOT_W-1:0]   rr_ptr, free_slot, pick_slot, cand;
   logic                has_free, has_pick, ar_hs, r_load;

   logic unused_bits;
   assign unused_bits = ^{S_AXI_AWADDR[31:IDX_W+2], S_AXI_AWADDR[1:0], S_AXI_AWSIZE,
                          S_AXI_AWPROT, S_AXI_AWCACHE, S_AXI_AWLOCK, S_AXI_AWQOS, S_AXI_AWREGION,
                          S_AXI_ARADDR[31:IDX_W+2], S_AXI_ARADDR[1:0], S_AXI_ARSIZE,
                          S_AXI_ARPROT, S_AXI_ARCACHE, S_AXI_ARLOCK, S_AXI_ARQOS, S_AXI_ARREGION};

   assign aw_hs   = S_AXI_AWVALID && S_AXI_AWREADY;
   assign w_hs    = S_AXI_WVALID && S_AXI_WREADY;
   assign w_final = (w_cnt == w_len);

   // ready_en keeps AWREADY/ARREADY low through the reset cycles themselves
   always_ff @(posedge ACLK) begin
      if (!ARESETn) begin
         w_state  <= W_IDLE;
         ready_en <= 1'b0;
      end else begin
         w_state  <= w_next;
         ready_en <= 1'b1;
      end
   end

   always_comb begin
      w_next = w_state;
      case (w_state)
         W_IDLE:  if (aw_hs) w_next = W_DATA;
         W_DATA:  if (w_hs && w_final) w_next = W_RESP;
         W_RESP:  if (S_AXI_BREADY) w_next = W_IDLE;
         default: w_next = W_IDLE;
      endcase
   end

   always_comb begin
      S_AXI_AWREADY = 1'b0;
      S_AXI_WREADY  = 1'b0;
      S_AXI_BVALID  = 1'b0;
      S_AXI_BRESP   = 2'b00;
      S_AXI_BID     = w_id;
      case (w_state)
         W_IDLE: S_AXI_AWREADY = ready_en;
         W_DATA: S_AXI_WREADY  = 1'b1;
         W_RESP: begin
            S_AXI_BVALID = 1'b1;
            S_AXI_BRESP  = w_err ? 2'b10 : 2'b00;
         end
         default: ;
      endcase
   end

   always_ff @(posedge ACLK) begin
      if (!ARESETn) begin
         w_id    <= '0;
         w_idx   <= '0;
         w_len   <= '0;
         w_cnt   <= '0;
         w_fixed <= 1'b0;
         w_err   <= 1'b0;
      end else if (aw_hs) begin
         w_id    <= S_AXI_AWID;
         w_idx   <= S_AXI_AWADDR[IDX_W+1:2];
         w_len   <= S_AXI_AWLEN;
         w_fixed <= (S_AXI_AWBURST == 2'b00);
         w_cnt   <= '0;
         w_err   <= 1'b0;
      end else if (w_hs) begin
         if (!w_fixed) w_idx <= w_idx + IDX_W'(1);
         w_cnt <= w_cnt + 8'd1;
         if (S_AXI_WLAST != w_final) w_err <= 1'b1;
      end
   end

   always_ff @(posedge ACLK) begin
      if (ARESETn && w_hs) begin
         for (int b = 0; b < 4; b++) begin
            if (S_AXI_WSTRB[b]) mem[w_idx][8*b +: 8] <= S_AXI_WDATA[8*b +: 8];
         end
      end
   end

   always_comb begin
      has_free  = 1'b0;
      free_slot = '0;
      for (int i = RD_SLOTS-1; i >= 0; i--) begin
         if (!s_valid[i]) begin
            has_free  = 1'b1;
            free_slot = SLOT_W'(i);
         end
      end
   end

   // descending scan so the smallest circular offset from rr_ptr wins
   always_comb begin
      has_pick  = 1'b0;
      pick_slot = '0;
      cand      = '0;
      for (int i = RD_SLOTS-1; i >= 0; i--) begin
         cand = rr_ptr + SLOT_W'(i);
         if (s_valid[cand]) begin
            has_pick  = 1'b1;
            pick_slot = cand;
         end
      end
   end

   assign S_AXI_ARREADY = ready_en && has_free;
   assign S_AXI_RRESP   = 2'b00;
   assign ar_hs  = S_AXI_ARVALID && S_AXI_ARREADY;
   assign r_load = has_pick && (!S_AXI_RVALID || S_AXI_RREADY);

   always_ff @(posedge ACLK) begin
      if (!ARESETn) begin
         s_valid      <= '0;
         s_fixed      <= '0;
         rr_ptr       <= '0;
         S_AXI_RVALID <= 1'b0;
         S_AXI_RID    <= '0;
         S_AXI_RDATA  <= '0;
         S_AXI_RLAST  <= 1'b0;
         for (int i = 0; i < RD_SLOTS; i++) begin
            s_id[i]  <= '0;
            s_idx[i] <= '0;
            s_rem[i] <= '0;
         end
      end else begin
         if (ar_hs) begin
            s_valid[free_slot] <= 1'b1;
            s_id[free_slot]    <= S_AXI_ARID;
            s_idx[free_slot]   <= S_AXI_ARADDR[IDX_W+1:2];
            s_rem[free_slot]   <= S_AXI_ARLEN;
            s_fixed[free_slot] <= (S_AXI_ARBURST == 2'b00);
         end
         if (r_load) begin
            S_AXI_RVALID <= 1'b1;
            S_AXI_RID    <= s_id[pick_slot];
            S_AXI_RDATA  <= mem[s_idx[pick_slot]];
            S_AXI_RLAST  <= (s_rem[pick_slot] == 8'd0);
            if (!s_fixed[pick_slot]) s_idx[pick_slot] <= s_idx[pick_slot] + IDX_W'(1);
            s_rem[pick_slot] <= s_rem[pick_slot] - 8'd1;
            if (s_rem[pick_slot] == 8'd0) s_valid[pick_slot] <= 1'b0;
            rr_ptr <= pick_slot + SLOT_W'(1);
         end else if (S_AXI_RREADY) begin
            S_AXI_RVALID <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_axi4_id_slave_mem.sv
`timescale 1ns/1ps
// Directed bench for axi4_id_slave_mem: table of write/readback bursts plus
// hand sequences for interleaving, back-pressure, reset abandonment and wrap.
module tb_axi4_id_slave_mem;
   typedef logic [3:0][31:0] quad_t;

   typedef struct {
      logic [3:0]  id;
      logic [31:0] addr;
      logic [7:0]  len;
      logic [1:0]  burst;
      logic [3:0]  strb;
      quad_t       wdata;
      logic [7:0]  last_at;
      logic [1:0]  exp_bresp;
      logic [3:0]  rid;
      quad_t       exp_rdata;
   } vec_t;

   logic ACLK = 1'b0;
   logic ARESETn = 1'b0;
   logic [3:0]  AWID = '0, ARID = '0;
   logic [31:0] AWADDR = '0, ARADDR = '0;
   logic [7:0]  AWLEN = '0, ARLEN = '0;
   logic [2:0]  AWSIZE = 3'd2, ARSIZE = 3'd2;
   logic [1:0]  AWBURST = 2'b01, ARBURST = 2'b01;
   logic        AWVALID = 1'b0, ARVALID = 1'b0;
   logic [31:0] WDATA = '0;
   logic [3:0]  WSTRB = '0;
   logic        WLAST = 1'b0, WVALID = 1'b0, BREADY = 1'b0, RREADY = 1'b0;
   logic        AWREADY, WREADY, BVALID, ARREADY, RLAST, RVALID;
   logic [3:0]  BID, RID;
   logic [1:0]  BRESP, RRESP;
   logic [31:0] RDATA;

   int total = 0;
   int bad = 0;
   vec_t vecs[5];

   always #5 ACLK = ~ACLK;

   axi4_id_slave_mem #(.ID_W(4), .MEM_WORDS(64), .RD_SLOTS(4)) dut (
      .ACLK(ACLK), .ARESETn(ARESETn),
      .S_AXI_AWID(AWID), .S_AXI_AWADDR(AWADDR), .S_AXI_AWLEN(AWLEN), .S_AXI_AWSIZE(AWSIZE),
      .S_AXI_AWBURST(AWBURST), .S_AXI_AWPROT(3'd0), .S_AXI_AWCACHE(4'd0), .S_AXI_AWLOCK(1'b0),
      .S_AXI_AWQOS(4'd0), .S_AXI_AWREGION(4'd0), .S_AXI_AWVALID(AWVALID), .S_AXI_AWREADY(AWREADY),
      .S_AXI_WDATA(WDATA), .S_AXI_WSTRB(WSTRB), .S_AXI_WLAST(WLAST), .S_AXI_WVALID(WVALID),
      .S_AXI_WREADY(WREADY), .S_AXI_BID(BID), .S_AXI_BRESP(BRESP), .S_AXI_BVALID(BVALID),
      .S_AXI_BREADY(BREADY),
      .S_AXI_ARID(ARID), .S_AXI_ARADDR(ARADDR), .S_AXI_ARLEN(ARLEN), .S_AXI_ARSIZE(ARSIZE),
      .S_AXI_ARBURST(ARBURST), .S_AXI_ARPROT(3'd0), .S_AXI_ARCACHE(4'd0), .S_AXI_ARLOCK(1'b0),
      .S_AXI_ARQOS(4'd0), .S_AXI_ARREGION(4'd0), .S_AXI_ARVALID(ARVALID), .S_AXI_ARREADY(ARREADY),
      .S_AXI_RID(RID), .S_AXI_RDATA(RDATA), .S_AXI_RRESP(RRESP), .S_AXI_RLAST(RLAST),
      .S_AXI_RVALID(RVALID), .S_AXI_RREADY(RREADY)
   );

   function automatic quad_t w4(input logic [31:0] a, b, c, d);
      quad_t q;
      q[0] = a; q[1] = b; q[2] = c; q[3] = d;
      return q;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge ACLK);
      #1;
   endtask

   task automatic chk_reset_vals();
      chk("rst_awready", 32'(AWREADY), 0);
      chk("rst_wready",  32'(WREADY),  0);
      chk("rst_bvalid",  32'(BVALID),  0);
      chk("rst_bresp",   32'(BRESP),   0);
      chk("rst_bid",     32'(BID),     0);
      chk("rst_arready", 32'(ARREADY), 0);
      chk("rst_rvalid",  32'(RVALID),  0);
      chk("rst_rlast",   32'(RLAST),   0);
      chk("rst_rid",     32'(RID),     0);
      chk("rst_rdata",   RDATA,        0);
   endtask

   task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [1:0] burst, input logic [3:0] strb, input quad_t data,
                           input logic [7:0] last_at, input logic [1:0] exp_bresp);
      int n;
      AWID = id; AWADDR = addr; AWLEN = len; AWBURST = burst; AWVALID = 1'b1;
      n = 0;
      while (!AWREADY && n < 50) begin tick(); n++; end
      if (n >= 50) chk("aw_timeout", 0, 1);
      tick();
      AWVALID = 1'b0;
      for (int b = 0; b <= int'(len); b++) begin
         WDATA = data[b]; WSTRB = strb; WLAST = (b == int'(last_at)); WVALID = 1'b1;
         n = 0;
         while (!WREADY && n < 50) begin tick(); n++; end
         if (n >= 50) chk("w_timeout", 0, 1);
         tick();
      end
      WVALID = 1'b0; WLAST = 1'b0;
      chk("b_latency", 32'(BVALID), 1);
      n = 0;
      while (!BVALID && n < 50) begin tick(); n++; end
      chk("bid", 32'(BID), 32'(id));
      chk("bresp", 32'(BRESP), 32'(exp_bresp));
      BREADY = 1'b1;
      tick();
      BREADY = 1'b0;
      chk("b_drop", 32'(BVALID), 0);
   endtask

   task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [1:0] burst, input quad_t exp);
      int n;
      ARID = id; ARADDR = addr; ARLEN = len; ARBURST = burst; ARVALID = 1'b1;
      n = 0;
      while (!ARREADY && n < 50) begin tick(); n++; end
      if (n >= 50) chk("ar_timeout", 0, 1);
      tick();
      ARVALID = 1'b0;
      tick();
      chk("r_latency", 32'(RVALID), 1);
      for (int b = 0; b <= int'(len); b++) begin
         n = 0;
         while (!RVALID && n < 50) begin tick(); n++; end
         chk("rdata", RDATA, exp[b]);
         chk("rid", 32'(RID), 32'(id));
         chk("rresp", 32'(RRESP), 0);
         chk("rlast", 32'(RLAST), 32'(b == int'(len)));
         tick();
      end
   endtask

   initial begin
      int pos, stall, accept_pos, n;
      logic seen, hs_ar, hs_r, saw_b, saw_r;
      logic [31:0] h_data, exp_d;
      logic [3:0]  h_id, exp_id;
      logic        exp_last;

      vecs[0] = '{id:4'd3, addr:32'h10, len:8'd3, burst:2'b01, strb:4'hF,
                  wdata:w4(32'h10000004, 32'h10000005, 32'h10000006, 32'h10000007),
                  last_at:8'd3, exp_bresp:2'b00, rid:4'd5,
                  exp_rdata:w4(32'h10000004, 32'h10000005, 32'h10000006, 32'h10000007)};
      vecs[1] = '{id:4'd1, addr:32'h00, len:8'd3, burst:2'b00, strb:4'hF,
                  wdata:w4(32'hA0A00001, 32'hA0A00002, 32'hA0A00003, 32'hA0A00004),
                  last_at:8'd3, exp_bresp:2'b00, rid:4'd2,
                  exp_rdata:w4(32'hA0A00004, 32'hA0A00004, 32'hA0A00004, 32'hA0A00004)};
      vecs[2] = '{id:4'd7, addr:32'h20, len:8'd3, burst:2'b01, strb:4'hF,
                  wdata:w4(32'h20000000, 32'h20000001, 32'h20000002, 32'h20000003),
                  last_at:8'd1, exp_bresp:2'b10, rid:4'd8,
                  exp_rdata:w4(32'h20000000, 32'h20000001, 32'h20000002, 32'h20000003)};
      vecs[3] = '{id:4'd4, addr:32'h40, len:8'd0, burst:2'b01, strb:4'hF,
                  wdata:w4(32'h11223344, 0, 0, 0),
                  last_at:8'd0, exp_bresp:2'b00, rid:4'd4,
                  exp_rdata:w4(32'h11223344, 0, 0, 0)};
      vecs[4] = '{id:4'd15, addr:32'h40, len:8'd0, burst:2'b01, strb:4'h3,
                  wdata:w4(32'hAABBCCDD, 0, 0, 0),
                  last_at:8'd0, exp_bresp:2'b00, rid:4'd0,
                  exp_rdata:w4(32'h1122CCDD, 0, 0, 0)};

      repeat (3) tick();
      chk_reset_vals();
      ARESETn = 1'b1;
      RREADY = 1'b1;
      tick();
      chk("post_rst_awready", 32'(AWREADY), 1);
      chk("post_rst_arready", 32'(ARREADY), 1);
      chk("post_rst_rvalid",  32'(RVALID),  0);
      chk("post_rst_bvalid",  32'(BVALID),  0);

      for (int v = 0; v < 5; v++) begin
         do_write(vecs[v].id, vecs[v].addr, vecs[v].len, vecs[v].burst, vecs[v].strb,
                  vecs[v].wdata, vecs[v].last_at, vecs[v].exp_bresp);
         do_read(vecs[v].rid, vecs[v].addr, vecs[v].len, vecs[v].burst, vecs[v].exp_rdata);
      end

      // interleave region: word idx holds 0x5000_0000 + idx for idx 32..47
      for (int k = 0; k < 4; k++) begin
         do_write(4'(k), 32'((32 + 4*k) * 4), 8'd3, 2'b01, 4'hF,
                  w4(32'h50000000 + 32'(32 + 4*k), 32'h50000000 + 32'(33 + 4*k),
                     32'h50000000 + 32'(34 + 4*k), 32'h50000000 + 32'(35 + 4*k)),
                  8'd3, 2'b00);
      end

      RREADY = 1'b0;
      for (int k = 0; k < 4; k++) begin
         ARID = 4'(k); ARADDR = 32'((32 + 4*k) * 4); ARLEN = 8'd3; ARBURST = 2'b01; ARVALID = 1'b1;
         n = 0;
         while (!ARREADY && n < 50) begin tick(); n++; end
         if (n >= 50) chk("ar_timeout", 0, 1);
         tick();
      end
      ARVALID = 1'b0;
      chk("ar_full", 32'(ARREADY), 0);

      ARID = 4'd9; ARADDR = 32'h10; ARLEN = 8'd0; ARBURST = 2'b01; ARVALID = 1'b1;
      pos = 0; stall = 0; accept_pos = -1; seen = 1'b0; h_data = '0; h_id = '0;
      for (int cyc = 0; cyc < 200 && pos < 17; cyc++) begin
         if (RVALID) begin
            if (!seen) begin
               exp_id   = (pos < 16) ? 4'(pos % 4) : 4'd9;
               exp_d    = (pos < 16) ? 32'h50000000 + 32'(32 + 4*(pos % 4) + pos / 4) : 32'h10000004;
               exp_last = (pos < 16) ? (pos / 4 == 3) : 1'b1;
               chk("il_rid", 32'(RID), 32'(exp_id));
               chk("il_rdata", RDATA, exp_d);
               chk("il_rlast", 32'(RLAST), 32'(exp_last));
               h_data = RDATA; h_id = RID; seen = 1'b1;
            end else begin
               chk("hold_rdata", RDATA, h_data);
               chk("hold_rid", 32'(RID), 32'(h_id));
            end
         end
         if (ARVALID && ARREADY && accept_pos < 0) accept_pos = pos;
         RREADY = !(pos == 5 && stall < 5);
         if (!RREADY) stall++;
         hs_ar = ARVALID && ARREADY;
         hs_r  = RVALID && RREADY;
         tick();
         if (hs_ar) ARVALID = 1'b0;
         if (hs_r) begin pos++; seen = 1'b0; end
      end
      ARVALID = 1'b0;
      RREADY = 1'b1;
      chk("ar5_gate_pos", 32'(accept_pos), 12);
      chk("il_beats", 32'(pos), 17);
      chk("stall_cycles", 32'(stall), 5);

      // reset while a read is stalled and a write is in W_DATA
      RREADY = 1'b0;
      ARID = 4'd1; ARADDR = 32'h80; ARLEN = 8'd7; ARBURST = 2'b01; ARVALID = 1'b1;
      n = 0;
      while (!ARREADY && n < 50) begin tick(); n++; end
      tick();
      ARVALID = 1'b0;
      AWID = 4'd6; AWADDR = 32'hC0; AWLEN = 8'd3; AWBURST = 2'b01; AWVALID = 1'b1;
      n = 0;
      while (!AWREADY && n < 50) begin tick(); n++; end
      tick();
      AWVALID = 1'b0;
      chk("pre_rst_rvalid", 32'(RVALID), 1);
      for (int b = 0; b < 2; b++) begin
         WDATA = 32'hDEAD0000 + 32'(b); WSTRB = 4'hF; WLAST = 1'b0; WVALID = 1'b1;
         tick();
      end
      WVALID = 1'b0;
      chk("pre_rst_wready", 32'(WREADY), 1);
      ARESETn = 1'b0;
      tick();
      chk_reset_vals();
      tick();
      ARESETn = 1'b1;
      RREADY = 1'b1;
      BREADY = 1'b1;
      saw_b = 1'b0; saw_r = 1'b0;
      tick();
      chk("rst2_awready", 32'(AWREADY), 1);
      chk("rst2_arready", 32'(ARREADY), 1);
      for (int c = 0; c < 8; c++) begin
         if (BVALID) saw_b = 1'b1;
         if (RVALID) saw_r = 1'b1;
         tick();
      end
      BREADY = 1'b0;
      chk("no_b_after_rst", 32'(saw_b), 0);
      chk("no_r_after_rst", 32'(saw_r), 0);

      do_write(4'd2, 32'hFC, 8'd1, 2'b01, 4'hF, w4(32'hC0000000, 32'hC0000001, 0, 0), 8'd1, 2'b00);
      do_read(4'd6, 32'hFC, 8'd1, 2'b01, w4(32'hC0000000, 32'hC0000001, 0, 0));
      do_read(4'd7, 32'h00, 8'd0, 2'b01, w4(32'hC0000001, 0, 0, 0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
